// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the multi-ported register file
// and the pipeline stages that consume it.
package regfile_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_NREGS = 32;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_init_ctr.sv
// Clear-pointer walk and INIT/RUN sequencing for regfile_mp.
module regfile_init_ctr
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned AW    = $clog2(DEF_NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] ptr,
  output logic          clr_we,
  output logic          ready
);

  state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      ptr   <= '0;
    end else if (state == INIT) begin
      ptr <= ptr + 1'b1;
      if (ptr == AW'(NREGS - 1)) begin
        state <= RUN;
      end
    end
  end

  assign clr_we = (state == INIT) && !reset;
  assign ready  = (state == RUN);

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file: walked clear after reset, registered reads with
// write-first bypass, highest-index write port wins, r0 hardwired to zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN  = DEF_XLEN,
  parameter  int unsigned NREGS = DEF_NREGS,
  parameter  int unsigned NRD   = 2,
  parameter  int unsigned NWR   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NWR-1:0]            wb_en,
  input  logic [NWR-1:0][AW-1:0]    wb_addr,
  input  logic [NWR-1:0][XLEN-1:0]  wb_data,
  input  logic [NRD-1:0]            rd_en,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  output logic [NRD-1:0][XLEN-1:0]  rd_data,
  output logic                      ready
);

  logic [XLEN-1:0]           regs [NREGS];
  logic [AW-1:0]             ptr;
  logic                      clr_we;
  logic [NRD-1:0][XLEN-1:0]  rd_next;

  regfile_init_ctr #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_init_ctr (
    .clk    (clk),
    .reset  (reset),
    .ptr    (ptr),
    .clr_we (clr_we),
    .ready  (ready)
  );

  // Later ports are visited last, so their non-blocking update takes effect.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[ptr] <= '0;
    end else if (ready && !reset) begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wb_en[j] && (wb_addr[j] != '0)) begin
          regs[wb_addr[j]] <= wb_data[j];
        end
      end
    end
  end

  always_comb begin
    rd_next = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_next[i] = regs[rd_addr[i]];
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wb_en[j] && (wb_addr[j] == rd_addr[i])) begin
          rd_next[i] = wb_data[j];
        end
      end
      if (rd_addr[i] == '0) begin
        rd_next[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (ready) begin
      for (int unsigned i = 0; i < NRD; i++) begin
        if (rd_en[i]) begin
          rd_data[i] <= rd_next[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed-vector bench for regfile_mp at default parameters.
module tb_regfile_mp;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       wb_en;
  logic [1:0][4:0]  wb_addr;
  logic [1:0][31:0] wb_data;
  logic [1:0]       rd_en;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic             ready;

  int vectors = 0;
  int miscompares = 0;

  regfile_mp #(
    .XLEN  (32),
    .NREGS (32),
    .NRD   (2),
    .NWR   (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr2(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                     input logic [4:0] a1, input logic [31:0] d1);
    wb_en = en; wb_addr[0] = a0; wb_data[0] = d0; wb_addr[1] = a1; wb_data[1] = d1;
    tick();
    wb_en = '0;
  endtask

  task automatic rd2(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
    rd_en = en; rd_addr[0] = a0; rd_addr[1] = a1;
    tick();
    rd_en = '0;
  endtask

  // Deassert reset and count cycles until ready rises (bounded).
  task automatic count_clear(output int n);
    reset = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    tick();
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready: got %b want 0", ready);
    end
    vectors++;
    if (rd_data !== '0) begin
      miscompares++; $display("FAIL reset_rd_data: got %h want 0", rd_data);
    end
    count_clear(n);
    vectors++;
    if (n !== 32) begin
      miscompares++; $display("FAIL boot_clear_len: got %0d want 32", n);
    end
    for (int r = 1; r < 32; r++) wr2(2'b01, 5'(r), 32'hA5000000 | r, 5'd0, 32'd0);
    reset = 1'b1;
    tick();
    vectors++;
    if (ready !== 1'b0 || rd_data !== '0) begin
      miscompares++; $display("FAIL pulse_reset_state: got ready=%b rd=%h want 0/0", ready, rd_data);
    end
    count_clear(n);
    vectors++;
    if (n !== 32) begin
      miscompares++; $display("FAIL pulse_clear_len: got %0d want 32", n);
    end
    for (int r = 0; r < 32; r++) begin
      rd2(2'b11, 5'(r), 5'(31 - r));
      vectors++;
      if (rd_data !== '0) begin
        miscompares++; $display("FAIL cleared_r%0d: got %h want 0", r, rd_data);
      end
    end
  endtask

  task automatic test_basic_rw();
    wr2(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
    rd2(2'b10, 5'd0, 5'd5);
    vectors++;
    if (rd_data[1] !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL basic_r5: got %h want deadbeef", rd_data[1]);
    end
  endtask

  task automatic test_r0();
    wr2(2'b10, 5'd0, 32'd0, 5'd0, 32'h12345678);
    rd2(2'b01, 5'd0, 5'd0);
    vectors++;
    if (rd_data[0] !== 32'h0) begin
      miscompares++; $display("FAIL r0_read: got %h want 0", rd_data[0]);
    end
    wb_en = 2'b11; wb_addr[0] = 5'd0; wb_data[0] = 32'hFFFFFFFF;
    wb_addr[1] = 5'd0; wb_data[1] = 32'h12345678;
    rd2(2'b11, 5'd0, 5'd0);
    wb_en = '0;
    vectors++;
    if (rd_data !== '0) begin
      miscompares++; $display("FAIL r0_bypass: got %h want 0", rd_data);
    end
  endtask

  task automatic test_bypass_priority();
    wb_en = 2'b11; wb_addr[0] = 5'd7; wb_data[0] = 32'hAAAA0000;
    wb_addr[1] = 5'd7; wb_data[1] = 32'h5555FFFF;
    rd2(2'b11, 5'd7, 5'd7);
    wb_en = '0;
    vectors++;
    if (rd_data[0] !== 32'h5555FFFF || rd_data[1] !== 32'h5555FFFF) begin
      miscompares++; $display("FAIL bypass_prio: got %h want 5555ffff x2", rd_data);
    end
    rd2(2'b01, 5'd7, 5'd0);
    vectors++;
    if (rd_data[0] !== 32'h5555FFFF) begin
      miscompares++; $display("FAIL prio_stored: got %h want 5555ffff", rd_data[0]);
    end
  endtask

  task automatic test_rd_hold();
    wr2(2'b01, 5'd3, 32'h11111111, 5'd0, 32'd0);
    rd2(2'b01, 5'd3, 5'd0);
    vectors++;
    if (rd_data[0] !== 32'h11111111) begin
      miscompares++; $display("FAIL hold_initial: got %h want 11111111", rd_data[0]);
    end
    wr2(2'b10, 5'd0, 32'd0, 5'd3, 32'h22222222);
    tick();
    vectors++;
    if (rd_data[0] !== 32'h11111111) begin
      miscompares++; $display("FAIL hold_kept: got %h want 11111111", rd_data[0]);
    end
    rd2(2'b01, 5'd3, 5'd0);
    vectors++;
    if (rd_data[0] !== 32'h22222222) begin
      miscompares++; $display("FAIL hold_reenable: got %h want 22222222", rd_data[0]);
    end
  endtask

  task automatic test_init_ignore();
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    wb_en = 2'b11; wb_addr[0] = 5'd3; wb_data[0] = 32'h0BAD0BAD;
    wb_addr[1] = 5'd4; wb_data[1] = 32'h0BAD0BAE;
    rd_en = 2'b11; rd_addr[0] = 5'd3; rd_addr[1] = 5'd4;
    tick();
    wb_en = '0; rd_en = '0;
    vectors++;
    if (ready !== 1'b0 || rd_data !== '0) begin
      miscompares++; $display("FAIL init_ignore: got ready=%b rd=%h want 0/0", ready, rd_data);
    end
    count_clear(n);
    vectors++;
    if (n !== 21) begin
      miscompares++; $display("FAIL init_remaining: got %0d want 21", n);
    end
    rd2(2'b11, 5'd3, 5'd4);
    vectors++;
    if (rd_data !== '0) begin
      miscompares++; $display("FAIL init_write_dropped: got %h want 0", rd_data);
    end
  endtask

  task automatic test_mid_reset_init();
    int n;
    wr2(2'b11, 5'd20, 32'h20202020, 5'd30, 32'h30303030);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("FAIL midinit_ready: got %b want 0", ready);
    end
    count_clear(n);
    vectors++;
    if (n !== 32) begin
      miscompares++; $display("FAIL midinit_clear_len: got %0d want 32", n);
    end
    rd2(2'b11, 5'd20, 5'd30);
    vectors++;
    if (rd_data !== '0) begin
      miscompares++; $display("FAIL midinit_data: got %h want 0", rd_data);
    end
  endtask

  task automatic test_mid_reset_run();
    int n;
    wr2(2'b11, 5'd9, 32'h99999999, 5'd31, 32'hCAFEF00D);
    rd2(2'b11, 5'd9, 5'd31);
    vectors++;
    if (rd_data[0] !== 32'h99999999 || rd_data[1] !== 32'hCAFEF00D) begin
      miscompares++; $display("FAIL midrun_preload: got %h want cafef00d_99999999", rd_data);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (ready !== 1'b0 || rd_data !== '0) begin
      miscompares++; $display("FAIL midrun_reset: got ready=%b rd=%h want 0/0", ready, rd_data);
    end
    count_clear(n);
    vectors++;
    if (n !== 32) begin
      miscompares++; $display("FAIL midrun_clear_len: got %0d want 32", n);
    end
    rd2(2'b11, 5'd9, 5'd31);
    vectors++;
    if (rd_data !== '0) begin
      miscompares++; $display("FAIL midrun_data: got %h want 0", rd_data);
    end
  endtask

  initial begin
    reset = 1'b1;
    wb_en = '0; wb_addr = '0; wb_data = '0;
    rd_en = '0; rd_addr = '0;
    #2;
    test_reset();
    test_basic_rw();
    test_r0();
    test_bypass_priority();
    test_rd_hold();
    test_init_ignore();
    test_mid_reset_init();
    test_mid_reset_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count; power of two, >= 2.
REQ-003 SHALL have parameter NRD, default 2: number of read ports.
REQ-004 SHALL have parameter NWR, default 2: number of write ports.
REQ-005 SHALL derive AW = $clog2(NREGS); it is not user-settable.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port wb_en, input, NWR: per-port write enable.
REQ-009 SHALL have port wb_addr, input, NWR x AW: per-port write register number.
REQ-010 SHALL have port wb_data, input, NWR x XLEN: per-port write data.
REQ-011 SHALL have port rd_en, input, NRD: per-port read enable.
REQ-012 SHALL have port rd_addr, input, NRD x AW: per-port read register number.
REQ-013 SHALL have port rd_data, output, NRD x XLEN: registered read data.
REQ-014 SHALL have port ready, output, 1: high once the clear sequence is complete.

Function
REQ-015 SHALL implement two states, INIT and RUN; reset forces INIT with clear pointer 0.
REQ-016 In INIT, each cycle SHALL write zero to regs[ptr] and increment ptr.
REQ-017 SHALL transition INIT->RUN on the cycle after ptr = NREGS-1 is cleared, i.e. NREGS cycles after reset deasserts.
REQ-018 ready SHALL be 1 only in RUN.
REQ-019 In INIT, wb_en and rd_en SHALL be ignored and rd_data SHALL stay 0.
REQ-020 In RUN, read latency SHALL be 1 cycle: at edge t with rd_en[i]=1, rd_data[i] <= regs[rd_addr[i]].
REQ-021 With rd_en[i]=0, rd_data[i] SHALL hold its previous value.
REQ-022 Register 0 SHALL always read 0, and writes to address 0 SHALL be discarded.
REQ-023 A write with wb_en[j]=1 and wb_addr[j]!=0 SHALL update regs[wb_addr[j]] at the same edge.
REQ-024 When several write ports target the same address in one cycle, the highest-index port SHALL win.
REQ-025 Read and write to the same nonzero address in the same cycle SHALL be write-first: rd_data returns the winning wb_data.
REQ-026 Asserting reset mid-operation SHALL restart INIT, drop ready, and clear all registers again; no partial contents are retained.

Reset
REQ-027 Reset SHALL set state=INIT, ptr=0, ready=0, rd_data=0 for all ports on the edge where reset=1.
REQ-028 The register array SHALL NOT be cleared in one cycle; it is cleared only by the INIT walk.

Structure
REQ-029 Package regfile_pkg SHALL hold the state enum (INIT, RUN) and the default XLEN/NREGS constants shared with the decode and writeback stages.
REQ-030 The clear-pointer counter and INIT/RUN FSM SHALL be a sub-module, regfile_init_ctr, with outputs ptr, clr_we and ready.
REQ-031 The array, read ports and bypass/priority logic SHALL be in regfile_mp.

Verification
REQ-032 Reset clear: pre-load nonzero values, pulse reset 1 cycle -> ready=0 for exactly 32 cycles (default parameters), then 1; every register reads 0.
REQ-033 Basic read/write: write 0xDEADBEEF to r5 on port 0; next cycle read r5 on port 1 -> rd_data[1]=0xDEADBEEF one cycle later.
REQ-034 r0: write 0x12345678 to r0 -> subsequent read of r0 returns 0.
REQ-035 Bypass and priority: same cycle write r7=0xAAAA0000 (port 0), r7=0x5555FFFF (port 1), read r7 -> rd_data=0x5555FFFF; a later read also returns 0x5555FFFF.
REQ-036 Mid-operation reset: at INIT ptr=10, and separately in RUN after writes, assert reset -> ready=0, a full 32-cycle clear follows, and prior data reads back 0.
REQ-037 Read-enable hold: rd_en[0]=0 while r3 changes -> rd_data[0] is unchanged until rd_en[0] is reasserted.
